atable_palette_fetch: RTL and testbench
=======================================

Name: atable_palette_fetch

Overview:
- Downstream consumer of the combinational attribute-table ROM (128 x 8, 7-bit address).
- Takes the background pixel scan position, applies the frame scroll, drives the ROM address, samples the returned attribute byte and extracts the 2-bit palette select for the 16x16 quadrant under the pixel.
- Output feeds the background colour mux, alongside the pattern-table bit-planes, with fixed 2-cycle latency.

Parameters:
- H_VIS, 256, visible NES columns; px >= H_VIS is outside the picture.
- V_VIS, 240, visible NES rows; py >= V_VIS is outside the picture; vertical scroll wraps modulo V_VIS.

Ports:
- clk  in  1  system clock, all registers on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; 0 = stall, all pipeline registers hold.
- frame_start  in  1  single-cycle pulse; samples scroll_x/scroll_y.
- scroll_x  in  8  horizontal scroll in pixels.
- scroll_y  in  8  vertical scroll in pixels; values >= 240 saturate to 239.
- pix_valid  in  1  px/py qualify a pixel this cycle.
- px  in  9  pixel column.
- py  in  9  pixel row.
- atable_addr  out  7  address to the attribute ROM; registered.
- atable_dout  in  8  combinational ROM data for atable_addr.
- pal_valid  out  1  pal_sel is valid.
- pal_sel  out  2  background palette number 0..3.
- pal_in_vis  out  1  pixel was inside the visible area.

Behaviour:
- Reset state (rst_n = 0, asynchronous): atable_addr, pal_valid, pal_sel and pal_in_vis are 0; the scroll registers are 0; all pipeline valids are 0.
- Scroll registers:
  - Loaded on any clk edge with frame_start = 1, independent of en.
  - A pixel presented in the same cycle as frame_start uses the previous scroll value. The new value applies from the next cycle.
- Stage 0, combinational on the inputs:
  - ex = (px[7:0] + sx) mod 256.
  - ey = py + sy; if ey >= 240 then ey = ey - 240 (a 9-bit sum is sufficient).
  - vis = (px < H_VIS) and (py < V_VIS).
- Stage 1 register, when en = 1:
  - atable_addr = {1'b0, ey[7:5], ex[7:5]}.
  - The quadrant q1 = {ey[4], ex[4]}, the visible flag and pix_valid are registered alongside it.
  - When not visible, atable_addr is still updated; its value is don't-care.
- Stage 2 register, when en = 1:
  - Select from atable_dout by q1: 00 -> [1:0], 01 -> [3:2], 10 -> [5:4], 11 -> [7:6].
  - pal_sel = the selected bits if vis1, else 2'b00.
  - pal_in_vis = vis1; pal_valid = valid1.
- Latency: a pixel presented at edge N (en = 1 on consecutive edges) appears on pal_* after edge N+2.
  - Throughput is 1 pixel/cycle with no bubbles.
- Stall (en = 0):
  - Every stage register holds, including atable_addr, so the ROM output stays stable.
  - pal_valid keeps its value; the consumer gates with en.
- Simultaneous frame_start and en = 0: the scroll still loads; the pipeline holds.
- Reset mid-frame: the pipeline is flushed immediately (asynchronous); after release, output is valid from the third en-cycle.
- Wrap-around:
  - Horizontal wrap is at 256 (single nametable).
  - Vertical wrap is at 240, so attribute rows 7 (bytes 0x38-0x3F) are reached only for ey 224..239.

Decomposition:
- Shared package ntable_pkg holds:
  - constants NT_H_VIS = 256, NT_V_VIS = 240, ATABLE_AW = 7;
  - a function attr_quadrant_sel(byte, q) returning 2 bits.
- One natural sub-module: ntable_scroll_add. It is the combinational wrap adder (px, py, sx, sy -> ex, ey, vis) and is reused later by the pattern-table fetch stage.
- The ROM is instantiated by the parent and is not inside this block.

Test Plan:
- Reset and no scroll: assert rst_n = 0 mid-stream -> all outputs 0 asynchronously. Release, then present px = 0, py = 64 -> atable_addr = 0x10 after 1 edge; pal_sel = 0 (byte 0x88, bits[1:0] = 00) after 2 edges, pal_in_vis = 1.
- Quadrant select: px = 16, py = 64 -> pal_sel = 2 (0x88 bits[3:2]). Then px = 224, py = 48 -> addr 0x0F, byte 0x20, q = 10 -> pal_sel = 2. Then px = 240, py = 48 -> q = 11 -> pal_sel = 0.
- Horizontal scroll wrap: frame_start with scroll_x = 16. Then px = 248, py = 80 -> ex = 8, atable_addr = 0x10, pal_sel = 0. The pixel sent in the frame_start cycle itself uses scroll 0.
- Vertical wrap and saturation: scroll_y = 200, py = 50 -> ey = 10, addr row 0 -> pal_sel = 0. Then scroll_y = 250 (saturates to 239), py = 1 -> ey = 0.
- Out of range: px = 256 or py = 240 with pix_valid = 1 -> pal_valid = 1, pal_in_vis = 0, pal_sel = 0.
- Stall: stream 4 pixels, drop en for 3 cycles mid-stream -> atable_addr and pal_* frozen. After en returns, the outputs resume in order with no lost or duplicated pixel.

Source files
------------

// File: rtl/ntable_pkg.sv
// Shared constants and helpers for the nametable/attribute fetch path.
// Visible picture size, attribute ROM address width and quadrant decode.
package ntable_pkg;

    localparam int NT_H_VIS   = 256;
    localparam int NT_V_VIS   = 240;
    localparam int ATABLE_AW  = 7;

    // q = {ey[4], ex[4]}: 00 top-left, 01 top-right, 10 bottom-left, 11 bottom-right
    function automatic logic [1:0] attr_quadrant_sel(input logic [7:0] attr_byte,
                                                     input logic [1:0] q);
        logic [1:0] sel;
        case (q)
            2'b00:   sel = attr_byte[1:0];
            2'b01:   sel = attr_byte[3:2];
            2'b10:   sel = attr_byte[5:4];
            default: sel = attr_byte[7:6];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ntable_scroll_add.sv
// Combinational scroll adder: horizontal wrap at 256, vertical wrap at the
// visible height, plus the inside-picture flag.
module ntable_scroll_add
    import ntable_pkg::*;
(
    input  logic [8:0] px,
    input  logic [8:0] py,
    input  logic [7:0] sx,
    input  logic [7:0] sy,
    output logic [7:0] ex,
    output logic [8:0] ey,
    output logic       vis
);

    logic [9:0] sum_y;
    logic       unused_sum_msb;

    always_comb begin
        ex    = px[7:0] + sx;
        sum_y = {1'b0, py} + {2'b00, sy};
        // Only one subtraction: for visible rows the sum is below twice the height.
        if (sum_y >= 10'(NT_V_VIS)) begin
            sum_y = sum_y - 10'(NT_V_VIS);
        end
        ey  = sum_y[8:0];
        vis = (px < 9'(NT_H_VIS)) && (py < 9'(NT_V_VIS));
    end

    assign unused_sum_msb = sum_y[9];

endmodule

// File: rtl/atable_palette_fetch.sv
// Attribute-table palette fetch: scroll, ROM address, quadrant select.
// Two-stage pipeline with stall; scroll registers load on frame_start regardless of en.
module atable_palette_fetch
    import ntable_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 frame_start,
    input  logic [7:0]           scroll_x,
    input  logic [7:0]           scroll_y,
    input  logic                 pix_valid,
    input  logic [8:0]           px,
    input  logic [8:0]           py,
    output logic [ATABLE_AW-1:0] atable_addr,
    input  logic [7:0]           atable_dout,
    output logic                 pal_valid,
    output logic [1:0]           pal_sel,
    output logic                 pal_in_vis
);

    logic [7:0]           sx_q, sx_d;
    logic [7:0]           sy_q, sy_d;
    logic [ATABLE_AW-1:0] addr_q, addr_d;
    logic [1:0]           q1_q, q1_d;
    logic                 vis1_q, vis1_d;
    logic                 valid1_q, valid1_d;
    logic                 pal_valid_q, pal_valid_d;
    logic [1:0]           pal_sel_q, pal_sel_d;
    logic                 pal_in_vis_q, pal_in_vis_d;

    logic [7:0] ex;
    logic [8:0] ey;
    logic       vis0;
    logic       unused_bits;

    ntable_scroll_add u_scroll_add (
        .px  (px),
        .py  (py),
        .sx  (sx_q),
        .sy  (sy_q),
        .ex  (ex),
        .ey  (ey),
        .vis (vis0)
    );

    assign unused_bits = ^{ex[3:0], ey[8], ey[3:0]};

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        // Vertical scroll beyond the last visible row is clamped at load time.
        if (frame_start) begin
            sx_d = scroll_x;
            sy_d = (scroll_y >= 8'(NT_V_VIS)) ? 8'(NT_V_VIS - 1) : scroll_y;
        end
    end

    always_comb begin
        addr_d       = addr_q;
        q1_d         = q1_q;
        vis1_d       = vis1_q;
        valid1_d     = valid1_q;
        pal_valid_d  = pal_valid_q;
        pal_sel_d    = pal_sel_q;
        pal_in_vis_d = pal_in_vis_q;
        if (en) begin
            addr_d       = {1'b0, ey[7:5], ex[7:5]};
            q1_d         = {ey[4], ex[4]};
            vis1_d       = vis0;
            valid1_d     = pix_valid;
            pal_sel_d    = vis1_q ? attr_quadrant_sel(atable_dout, q1_q) : 2'b00;
            pal_in_vis_d = vis1_q;
            pal_valid_d  = valid1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q         <= '0;
            sy_q         <= '0;
            addr_q       <= '0;
            q1_q         <= '0;
            vis1_q       <= 1'b0;
            valid1_q     <= 1'b0;
            pal_valid_q  <= 1'b0;
            pal_sel_q    <= '0;
            pal_in_vis_q <= 1'b0;
        end else begin
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            addr_q       <= addr_d;
            q1_q         <= q1_d;
            vis1_q       <= vis1_d;
            valid1_q     <= valid1_d;
            pal_valid_q  <= pal_valid_d;
            pal_sel_q    <= pal_sel_d;
            pal_in_vis_q <= pal_in_vis_d;
        end
    end

    assign atable_addr = addr_q;
    assign pal_valid   = pal_valid_q;
    assign pal_sel     = pal_sel_q;
    assign pal_in_vis  = pal_in_vis_q;

endmodule

// File: tb/tb_atable_palette_fetch.sv
// Bench for atable_palette_fetch: ROM model, arithmetic reference model with
// per-cycle comparison, and directed literal checks.
module tb_atable_palette_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] scroll_x = '0;
    logic [7:0] scroll_y = '0;
    logic       pix_valid = 1'b0;
    logic [8:0] px = '0;
    logic [8:0] py = '0;
    logic [6:0] atable_addr;
    logic [7:0] atable_dout;
    logic       pal_valid;
    logic [1:0] pal_sel;
    logic       pal_in_vis;

    logic [7:0] rom [128];
    assign atable_dout = rom[atable_addr];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    atable_palette_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_start (frame_start),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .pix_valid   (pix_valid),
        .px          (px),
        .py          (py),
        .atable_addr (atable_addr),
        .atable_dout (atable_dout),
        .pal_valid   (pal_valid),
        .pal_sel     (pal_sel),
        .pal_in_vis  (pal_in_vis)
    );

    typedef struct {
        bit       v;
        bit       vis;
        int       addr;
        int       sel;
    } exp_t;

    exp_t m1 = '{0, 0, 0, 0};
    exp_t m2 = '{0, 0, 0, 0};
    int   m_sx = 0;
    int   m_sy = 0;

    function automatic exp_t predict(int x, int y, int sx, int sy, bit v);
        exp_t r;
        int ex, ey, q;
        ex     = ((x % 256) + sx) % 256;
        ey     = (y + sy) % 240;
        r.v    = v;
        r.vis  = (x < 256) && (y < 240);
        r.addr = (ey / 32) * 8 + (ex / 32);
        q      = ((ey / 16) % 2) * 2 + ((ex / 16) % 2);
        r.sel  = r.vis ? ((int'(rom[r.addr]) >> (2 * q)) % 4) : 0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1   = '{0, 0, 0, 0};
            m2   = '{0, 0, 0, 0};
            m_sx = 0;
            m_sy = 0;
        end else begin
            if (en) begin
                m2 = m1;
                m1 = predict(int'(px), int'(py), m_sx, m_sy, pix_valid);
            end
            if (frame_start) begin
                m_sx = int'(scroll_x);
                m_sy = (scroll_y >= 240) ? 239 : int'(scroll_y);
            end
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_pal_valid", int'(pal_valid), int'(m2.v));
        if (m2.v) begin
            check("model_pal_in_vis", int'(pal_in_vis), int'(m2.vis));
            check("model_pal_sel", int'(pal_sel), m2.sel);
        end
        if (m1.v && m1.vis) check("model_addr", int'(atable_addr), m1.addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(int x, int y);
        pix_valid = 1'b1;
        px = 9'(x);
        py = 9'(y);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'(i * 53 + 27);
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        rom[16] = 8'h88;
        rom[15] = 8'h20;

        // pin the reference model against hand-computed values
        begin
            exp_t r;
            r = predict(16, 64, 0, 0, 1'b1);
            check("pin_q01", r.sel, 2);
            r = predict(224, 48, 0, 0, 1'b1);
            check("pin_addr0f", r.addr, 15);
            r = predict(248, 80, 16, 0, 1'b1);
            check("pin_hwrap", r.addr, 16);
        end

        repeat (2) tick();
        check("rst_addr", int'(atable_addr), 0);
        check("rst_pal_valid", int'(pal_valid), 0);
        rst_n = 1'b1;
        tick();

        // quadrant select, no scroll
        en = 1'b1;
        pix(0, 64);    tick(); check("addr_0_64", int'(atable_addr), 16);
        pix(16, 64);   tick(); check("sel_0_64", int'(pal_sel), 0);
                               check("vis_0_64", int'(pal_in_vis), 1);
        pix(224, 48);  tick(); check("sel_16_64", int'(pal_sel), 2);
        pix(240, 48);  tick(); check("sel_224_48", int'(pal_sel), 2);
                               check("addr_240_48", int'(atable_addr), 15);
        pix_valid = 1'b0; tick(); check("sel_240_48", int'(pal_sel), 0);
        tick();

        // horizontal scroll; pixel in the frame_start cycle uses the old scroll
        frame_start = 1'b1; scroll_x = 8'd16; scroll_y = 8'd0;
        pix(248, 80);  tick(); check("addr_fs_old_scroll", int'(atable_addr), 23);
        frame_start = 1'b0;
        pix(248, 80);  tick(); check("addr_hwrap", int'(atable_addr), 16);
        pix_valid = 1'b0; tick(); check("sel_hwrap", int'(pal_sel), 0);
        tick();

        // vertical wrap and saturation
        frame_start = 1'b1; scroll_y = 8'd200; pix_valid = 1'b0; tick();
        frame_start = 1'b0;
        pix(0, 50);    tick(); check("addr_vwrap", int'(atable_addr), 0);
        pix_valid = 1'b0; tick(); check("sel_vwrap", int'(pal_sel), 0);
        frame_start = 1'b1; scroll_y = 8'd250; tick();
        frame_start = 1'b0;
        pix(0, 1);     tick(); check("addr_sat_py1", int'(atable_addr), 0);
        pix(0, 30);    tick(); check("addr_sat_py30", int'(atable_addr), 0);
        pix(64, 100);  tick();
        pix_valid = 1'b0; tick(); tick();

        // out of visible range
        pix(256, 10);  tick();
        pix(10, 240);  tick(); check("oor_valid", int'(pal_valid), 1);
                               check("oor_vis", int'(pal_in_vis), 0);
                               check("oor_sel", int'(pal_sel), 0);
        pix_valid = 1'b0; tick(); check("oor2_vis", int'(pal_in_vis), 0);
        tick();

        // stall mid-stream, with a scroll load during the stall
        frame_start = 1'b1; scroll_x = 8'd16; scroll_y = 8'd239; tick();
        frame_start = 1'b0;
        pix(32, 0);    tick();
        pix(64, 0);    tick(); check("addr_pre_stall", int'(atable_addr), 58);
        en = 1'b0; pix(96, 0);
        frame_start = 1'b1; scroll_x = 8'd0; scroll_y = 8'd0; tick();
        frame_start = 1'b0;
        tick(); check("addr_stall", int'(atable_addr), 58);
                check("valid_stall", int'(pal_valid), 1);
        tick();
        en = 1'b1;     tick(); check("addr_resume", int'(atable_addr), 3);
        pix(128, 16);  tick();
        pix_valid = 1'b0; tick(); tick();

        // asynchronous reset mid-stream
        pix(16, 64);   tick();
        pix(224, 48);  tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr", int'(atable_addr), 0);
        check("arst_valid", int'(pal_valid), 0);
        check("arst_sel", int'(pal_sel), 0);
        tick();
        rst_n = 1'b1;
        pix(16, 64);   tick();
        pix(224, 48);  tick(); check("post_rst_sel", int'(pal_sel), 2);
        pix_valid = 1'b0; tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
